// File: rtl/async_mon_pkg.sv
// Shared definitions for the asynchronous input monitor.
// Holds the debounce FSM state encoding, the default parameter values and
// a small helper that decodes the filtered level from an FSM state.
package async_mon_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } mon_state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int DEBOUNCE_DEF    = 3;
    localparam int CNT_W_DEF       = 8;
    // Debounce counter width: enough for DEBOUNCE up to 15.
    localparam int DEB_W           = 4;

    // Filtered level implied by a state: high while stable high or while
    // checking whether a high level is really going low.
    function automatic logic is_high_state(input mon_state_t st);
        logic hi;
        case (st)
            STABLE_HI: hi = 1'b1;
            CHK_LO:    hi = 1'b1;
            default:   hi = 1'b0;
        endcase
        return hi;
    endfunction

endpackage

// File: rtl/async_input_monitor_if.sv
// Signal bundle of the asynchronous input monitor.
// master: drives d_async/clr and observes the status outputs (bench side).
// slave : receives d_async/clr and drives q_sync, q_filt, rise, fall,
//         edge_cnt, last_width, ovf (monitor side).
interface async_input_monitor_if
    import async_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             d_async;
    logic             clr;
    logic             q_sync;
    logic             q_filt;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] last_width;
    logic             ovf;

    modport master (
        output d_async, clr,
        input  q_sync, q_filt, rise, fall, edge_cnt, last_width, ovf
    );

    modport slave (
        input  d_async, clr,
        output q_sync, q_filt, rise, fall, edge_cnt, last_width, ovf
    );
endinterface

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Ports: clk (sampling clock), rst (async active-low reset, clears all
// flops), d (asynchronous input), q (synchronized output, STAGES edges late).
module sync_ff_chain
    import async_mon_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_r;

    // Shift the input through the flop chain; bit 0 is the metastable stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];
endmodule

// File: rtl/async_input_monitor.sv
// Asynchronous input monitor: synchronizes d_async, debounces it with a
// four-state FSM and keeps edge statistics.
// Ports: clk, rst (async active-low), bus (slave modport):
//   d_async in, clr in (sync clear of statistics), q_sync, q_filt,
//   rise/fall (one-cycle pulses), edge_cnt (wrapping), last_width
//   (saturating length of the previous level), ovf (sticky wrap flag).
module async_input_monitor
    import async_mon_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEBOUNCE    = DEBOUNCE_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    async_input_monitor_if.slave  bus
);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
    // Count value that, with one more matching sample, completes debounce.
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic             q_sync_s;
    mon_state_t       state_r;
    mon_state_t       state_s;
    logic [DEB_W-1:0] deb_cnt_r;
    logic [DEB_W-1:0] deb_cnt_s;
    logic             rise_s;
    logic             fall_s;
    logic             q_filt_r;
    logic             rise_r;
    logic             fall_r;
    logic [CNT_W-1:0] run_cnt_r;
    logic [CNT_W-1:0] edge_cnt_r;
    logic [CNT_W-1:0] last_width_r;
    logic             ovf_r;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.d_async),
        .q   (q_sync_s)
    );

    // Debounce next-state logic; rise_s/fall_s mark an accepted transition.
    always_comb begin
        state_s   = state_r;
        deb_cnt_s = deb_cnt_r;
        rise_s    = 1'b0;
        fall_s    = 1'b0;
        case (state_r)
            STABLE_LO: begin
                if (q_sync_s) begin
                    if (DEBOUNCE == 1) begin
                        state_s   = STABLE_HI;
                        deb_cnt_s = '0;
                        rise_s    = 1'b1;
                    end else begin
                        state_s   = CHK_HI;
                        deb_cnt_s = DEB_ONE;
                    end
                end else begin
                    deb_cnt_s = '0;
                end
            end
            CHK_HI: begin
                if (!q_sync_s) begin
                    state_s   = STABLE_LO;
                    deb_cnt_s = '0;
                end else if (deb_cnt_r == DEB_LAST) begin
                    state_s   = STABLE_HI;
                    deb_cnt_s = '0;
                    rise_s    = 1'b1;
                end else begin
                    deb_cnt_s = deb_cnt_r + DEB_ONE;
                end
            end
            STABLE_HI: begin
                if (!q_sync_s) begin
                    if (DEBOUNCE == 1) begin
                        state_s   = STABLE_LO;
                        deb_cnt_s = '0;
                        fall_s    = 1'b1;
                    end else begin
                        state_s   = CHK_LO;
                        deb_cnt_s = DEB_ONE;
                    end
                end else begin
                    deb_cnt_s = '0;
                end
            end
            CHK_LO: begin
                if (q_sync_s) begin
                    state_s   = STABLE_HI;
                    deb_cnt_s = '0;
                end else if (deb_cnt_r == DEB_LAST) begin
                    state_s   = STABLE_LO;
                    deb_cnt_s = '0;
                    fall_s    = 1'b1;
                end else begin
                    deb_cnt_s = deb_cnt_r + DEB_ONE;
                end
            end
            default: begin
                state_s   = STABLE_LO;
                deb_cnt_s = '0;
            end
        endcase
    end

    // FSM state plus registered level/pulse outputs, all on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= STABLE_LO;
            deb_cnt_r <= '0;
            q_filt_r  <= 1'b0;
            rise_r    <= 1'b0;
            fall_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            deb_cnt_r <= deb_cnt_s;
            q_filt_r  <= is_high_state(state_s);
            rise_r    <= rise_s;
            fall_r    <= fall_s;
        end
    end

    // Edge statistics; clr wins over a coincident transition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cnt_r    <= '0;
            edge_cnt_r   <= '0;
            last_width_r <= '0;
            ovf_r        <= 1'b0;
        end else if (bus.clr) begin
            run_cnt_r    <= '0;
            edge_cnt_r   <= '0;
            last_width_r <= '0;
            ovf_r        <= 1'b0;
        end else if (rise_s || fall_s) begin
            last_width_r <= run_cnt_r;
            run_cnt_r    <= '0;
            edge_cnt_r   <= edge_cnt_r + CNT_ONE;
            if (edge_cnt_r == CNT_MAX) begin
                ovf_r <= 1'b1;
            end
        end else if (run_cnt_r != CNT_MAX) begin
            run_cnt_r <= run_cnt_r + CNT_ONE;
        end
    end

    assign bus.q_sync     = q_sync_s;
    assign bus.q_filt     = q_filt_r;
    assign bus.rise       = rise_r;
    assign bus.fall       = fall_r;
    assign bus.edge_cnt   = edge_cnt_r;
    assign bus.last_width = last_width_r;
    assign bus.ovf        = ovf_r;
endmodule

// File: tb/tb_async_input_monitor.sv
// Self-checking bench for async_input_monitor (SYNC_STAGES=2, DEBOUNCE=3,
// CNT_W=4). Stimulus pushes the expected pulse into a scoreboard queue; an
// independent monitor pops and compares on every rise/fall pulse.
module tb_async_input_monitor;
    localparam int LAT = 5;   // SYNC_STAGES + DEBOUNCE

    typedef struct {
        bit         is_rise;
        int         cyc;
        logic [3:0] ec;
        bit         ovf;
        bit         chk_lw;
        logic [3:0] lw;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t got_e;
    logic [3:0] exp_ec = 4'd0;
    bit         exp_ovf = 1'b0;

    async_input_monitor_if #(.CNT_W(4)) bus ();

    async_input_monitor #(
        .SYNC_STAGES (2),
        .DEBOUNCE    (3),
        .CNT_W       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int all_out();
        return int'({bus.q_sync, bus.q_filt, bus.rise, bus.fall,
                     bus.edge_cnt, bus.last_width, bus.ovf});
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Change d_async and queue the pulse it must produce LAT edges later.
    task automatic drive(input bit v, input bit chk_lw, input logic [3:0] lw);
        exp_t e;
        bus.d_async = v;
        exp_ec = exp_ec + 4'd1;
        if (exp_ec == 4'd0) exp_ovf = 1'b1;
        e.is_rise = v;
        e.cyc     = cyc + LAT;
        e.ec      = exp_ec;
        e.ovf     = exp_ovf;
        e.chk_lw  = chk_lw;
        e.lw      = lw;
        sb.push_back(e);
    endtask

    task automatic do_clr();
        bus.clr = 1'b1;
        step(1);
        bus.clr = 1'b0;
        exp_ec  = 4'd0;
        exp_ovf = 1'b0;
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.rise || bus.fall) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", int'({bus.rise, bus.fall}), 0);
            end else begin
                got_e = sb.pop_front();
                check("pulse_kind", int'({bus.rise, bus.fall}), got_e.is_rise ? 2 : 1);
                check("pulse_cycle", cyc, got_e.cyc);
                check("pulse_q_filt", int'(bus.q_filt), int'(got_e.is_rise));
                check("pulse_edge_cnt", int'(bus.edge_cnt), int'(got_e.ec));
                check("pulse_ovf", int'(bus.ovf), int'(got_e.ovf));
                if (got_e.chk_lw) check("pulse_last_width", int'(bus.last_width), int'(got_e.lw));
            end
        end
    end

    initial begin
        exp_t e;
        rst = 1'b0;
        bus.d_async = 1'b0;
        bus.clr = 1'b0;

        // Reset hold with d_async toggling at random 1-3 ns intervals.
        fork
            begin
                repeat (60) begin
                    #($urandom_range(3, 1));
                    bus.d_async = ~bus.d_async;
                end
            end
            begin
                repeat (10) begin
                    #9;
                    check("reset_hold_outputs", all_out(), 0);
                end
            end
        join
        bus.d_async = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("reset_state", all_out(), 0);
        step(2);

        // Glitch: two-cycle high pulse is filtered out.
        bus.d_async = 1'b1;
        step(2);
        bus.d_async = 1'b0;
        step(10);
        check("glitch_q_filt", int'(bus.q_filt), 0);
        check("glitch_edge_cnt", int'(bus.edge_cnt), 0);

        // Clean step held 20 cycles; q_sync appears after two edges.
        drive(1'b1, 1'b0, 4'd0);
        step(1);
        check("q_sync_lat1", int'(bus.q_sync), 0);
        step(1);
        check("q_sync_lat2", int'(bus.q_sync), 1);
        step(18);
        check("step_q_filt", int'(bus.q_filt), 1);
        check("step_edge_cnt", int'(bus.edge_cnt), 1);

        // Fall after 20 high cycles: 19 run counts saturate at 15.
        drive(1'b0, 1'b1, 4'd15);
        step(12);
        check("fall_edge_cnt", int'(bus.edge_cnt), 2);

        do_clr();
        check("clr_edge_cnt", int'(bus.edge_cnt), 0);
        check("clr_last_width", int'(bus.last_width), 0);

        // Width: rise, 10 non-transition edges, fall -> last_width 10.
        drive(1'b1, 1'b0, 4'd0);
        step(11);
        drive(1'b0, 1'b1, 4'd10);
        step(10);
        check("width_edge_cnt", int'(bus.edge_cnt), 2);

        // Rise after 9 low counts, then clr coincident with the fall edge.
        drive(1'b1, 1'b1, 4'd9);
        step(8);
        bus.d_async = 1'b0;
        e.is_rise = 1'b0;
        e.cyc     = cyc + LAT;
        e.ec      = 4'd0;
        e.ovf     = 1'b0;
        e.chk_lw  = 1'b1;
        e.lw      = 4'd0;
        sb.push_back(e);
        step(4);
        bus.clr = 1'b1;
        step(1);
        bus.clr = 1'b0;
        exp_ec  = 4'd0;
        exp_ovf = 1'b0;
        step(5);
        check("clr_fall_edge_cnt", int'(bus.edge_cnt), 0);

        // Wrap: 16 accepted edges on a 4-bit counter, 8 cycles apart.
        step(3);
        for (int k = 1; k <= 16; k++) begin
            drive(k % 2 == 1, k >= 2, 4'd7);
            step(8);
            check("wrap_edge_cnt", int'(bus.edge_cnt), k % 16);
            check("wrap_ovf", int'(bus.ovf), (k == 16) ? 1 : 0);
        end
        step(10);
        check("ovf_hold", int'(bus.ovf), 1);
        drive(1'b1, 1'b1, 4'd15);
        step(8);
        check("ovf_sticky", int'(bus.ovf), 1);
        do_clr();
        check("ovf_clr", int'(bus.ovf), 0);
        check("ovf_clr_edge_cnt", int'(bus.edge_cnt), 0);
        drive(1'b0, 1'b0, 4'd0);
        step(10);

        // Reset during CHK_HI: outputs clear at once, no rise afterwards.
        bus.d_async = 1'b1;
        step(3);
        #2;
        rst = 1'b0;
        #1;
        check("midop_reset_outputs", all_out(), 0);
        bus.d_async = 1'b0;
        step(3);
        #3;
        rst = 1'b1;
        step(15);
        check("post_reset_q_filt", int'(bus.q_filt), 0);
        check("post_reset_edge_cnt", int'(bus.edge_cnt), 0);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
